// File: rtl/ex_stage_pipe.sv
// Execute-stage slice: ID/EX register, operand bypass, load-use stall detect,
// ALU with carry/zero flags, and the EX/MEM register.
module ex_stage_pipe #(
  parameter int WORD_LEN  = 8,
  parameter int RID_LEN   = 3,
  parameter int SHAMT_LEN = $clog2(WORD_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [3:0]          id_op,
  input  logic [RID_LEN-1:0]  id_rs1,
  input  logic [RID_LEN-1:0]  id_rs2,
  input  logic [RID_LEN-1:0]  id_rd,
  input  logic [WORD_LEN-1:0] id_rs1_data,
  input  logic [WORD_LEN-1:0] id_rs2_data,
  input  logic [WORD_LEN-1:0] id_imm,
  input  logic [1:0]          id_src2_sel,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_rf_write_en,
  input  logic                id_flag_en,
  input  logic                flush,
  output logic                id_stall,
  input  logic                wb_valid,
  input  logic                wb_write_en,
  input  logic [RID_LEN-1:0]  wb_rd,
  input  logic [WORD_LEN-1:0] wb_data,
  output logic                em_valid,
  output logic                em_mem_read,
  output logic                em_mem_write,
  output logic                em_rf_write_en,
  output logic [WORD_LEN-1:0] em_alu_out,
  output logic [WORD_LEN-1:0] em_store_data,
  output logic [RID_LEN-1:0]  em_rd,
  output logic                c_flag,
  output logic                z_flag
);

  typedef struct packed {
    logic                valid;
    logic [3:0]          op;
    logic [RID_LEN-1:0]  rs1;
    logic [RID_LEN-1:0]  rs2;
    logic [RID_LEN-1:0]  rd;
    logic [WORD_LEN-1:0] rs1_data;
    logic [WORD_LEN-1:0] rs2_data;
    logic [WORD_LEN-1:0] imm;
    logic [1:0]          src2_sel;
    logic                mem_read;
    logic                mem_write;
    logic                rf_write_en;
    logic                flag_en;
  } idex_t;

  idex_t ie, id_bundle;

  always_comb begin
    id_bundle             = '0;
    id_bundle.valid       = id_valid;
    id_bundle.op          = id_op;
    id_bundle.rs1         = id_rs1;
    id_bundle.rs2         = id_rs2;
    id_bundle.rd          = id_rd;
    id_bundle.rs1_data    = id_rs1_data;
    id_bundle.rs2_data    = id_rs2_data;
    id_bundle.imm         = id_imm;
    id_bundle.src2_sel    = id_src2_sel;
    id_bundle.mem_read    = id_valid & id_mem_read;
    id_bundle.mem_write   = id_valid & id_mem_write;
    id_bundle.rf_write_en = id_valid & id_rf_write_en;
    id_bundle.flag_en     = id_valid & id_flag_en;
  end

  // rs2 only matters for the hazard when it is actually read (ALU operand or store data)
  assign id_stall = ie.valid & ie.mem_read & id_valid &
                    ((ie.rd == id_rs1) |
                     ((ie.rd == id_rs2) & ((id_src2_sel == 2'd0) | id_mem_write)));

  always_ff @(posedge clk) begin
    if (!rst)                  ie <= '0;
    else if (flush || id_stall) ie <= '0;
    else                       ie <= id_bundle;
  end

  logic em_fwd_ok;
  logic [WORD_LEN-1:0] fwd_a, fwd_b;

  // a load's EX/MEM value is an address, not the loaded data, so it never bypasses
  assign em_fwd_ok = em_valid & em_rf_write_en & ~em_mem_read;

  always_comb begin
    fwd_a = ie.rs1_data;
    if (em_fwd_ok && em_rd == ie.rs1)                     fwd_a = em_alu_out;
    else if (wb_valid && wb_write_en && wb_rd == ie.rs1)  fwd_a = wb_data;
    fwd_b = ie.rs2_data;
    if (em_fwd_ok && em_rd == ie.rs2)                     fwd_b = em_alu_out;
    else if (wb_valid && wb_write_en && wb_rd == ie.rs2)  fwd_b = wb_data;
  end

  logic [WORD_LEN-1:0]  op_b, b_add, alu_res;
  logic [SHAMT_LEN-1:0] s;
  logic                 cin, alu_c;
  logic [WORD_LEN:0]    sum, shl_t, shr_t;

  always_comb begin
    case (ie.src2_sel)
      2'd0:    op_b = fwd_b;
      2'd1:    op_b = ie.imm;
      2'd2:    op_b = {{(WORD_LEN-SHAMT_LEN){1'b0}}, ie.imm[SHAMT_LEN-1:0]};
      default: op_b = '0;
    endcase
    s     = op_b[SHAMT_LEN-1:0];
    b_add = (ie.op == 4'd2 || ie.op == 4'd3) ? ~op_b : op_b;
    case (ie.op)
      4'd1, 4'd3: cin = c_flag;
      4'd2:       cin = 1'b1;
      default:    cin = 1'b0;
    endcase
    sum   = {1'b0, fwd_a} + {1'b0, b_add} + {{WORD_LEN{1'b0}}, cin};
    // the extra bit catches the last bit shifted out; it is 0 when s == 0
    shl_t = {1'b0, fwd_a} << s;
    shr_t = {fwd_a, 1'b0} >> s;
    alu_c = 1'b0;
    case (ie.op)
      4'd0, 4'd1, 4'd2, 4'd3: begin alu_res = sum[WORD_LEN-1:0]; alu_c = sum[WORD_LEN]; end
      4'd4:  alu_res = fwd_a & op_b;
      4'd5:  alu_res = fwd_a | op_b;
      4'd6:  alu_res = fwd_a ^ op_b;
      4'd7:  alu_res = fwd_a & ~op_b;
      4'd8:  begin alu_res = shl_t[WORD_LEN-1:0]; alu_c = shl_t[WORD_LEN]; end
      4'd9:  begin alu_res = shr_t[WORD_LEN:1];   alu_c = shr_t[0]; end
      4'd10: alu_res = (fwd_a << s) | (fwd_a >> (WORD_LEN - int'(s)));
      4'd11: alu_res = (fwd_a >> s) | (fwd_a << (WORD_LEN - int'(s)));
      4'd12: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else if (ie.valid && ie.flag_en) begin
      c_flag <= alu_c;
      z_flag <= ~|alu_res;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      em_valid       <= 1'b0;
      em_mem_read    <= 1'b0;
      em_mem_write   <= 1'b0;
      em_rf_write_en <= 1'b0;
      em_alu_out     <= '0;
      em_store_data  <= '0;
      em_rd          <= '0;
    end else begin
      em_valid       <= ie.valid;
      em_mem_read    <= ie.valid & ie.mem_read;
      em_mem_write   <= ie.valid & ie.mem_write;
      em_rf_write_en <= ie.valid & ie.rf_write_en;
      em_alu_out     <= alu_res;
      em_store_data  <= fwd_b;
      em_rd          <= ie.rd;
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe: ALU vector table plus hand-built
// bypass, load-use, flush and reset sequences.
module tb_ex_stage_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_op;
  logic [2:0] id_rs1, id_rs2, id_rd;
  logic [7:0] id_rs1_data, id_rs2_data, id_imm;
  logic [1:0] id_src2_sel;
  logic       id_mem_read, id_mem_write, id_rf_write_en, id_flag_en;
  logic       flush;
  logic       id_stall;
  logic       wb_valid, wb_write_en;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic       em_valid, em_mem_read, em_mem_write, em_rf_write_en;
  logic [7:0] em_alu_out, em_store_data;
  logic [2:0] em_rd;
  logic       c_flag, z_flag;

  int errors = 0;
  int checks = 0;

  ex_stage_pipe #(.WORD_LEN(8), .RID_LEN(3)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_op(id_op),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_src2_sel(id_src2_sel),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_rf_write_en(id_rf_write_en), .id_flag_en(id_flag_en),
    .flush(flush), .id_stall(id_stall),
    .wb_valid(wb_valid), .wb_write_en(wb_write_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .em_valid(em_valid), .em_mem_read(em_mem_read), .em_mem_write(em_mem_write),
    .em_rf_write_en(em_rf_write_en), .em_alu_out(em_alu_out),
    .em_store_data(em_store_data), .em_rd(em_rd),
    .c_flag(c_flag), .z_flag(z_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b, imm;
    logic [1:0] sel;
    logic [7:0] exp_res;
    logic       exp_c, exp_z;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_op = 4'd0; id_rs1 = 3'd0; id_rs2 = 3'd0; id_rd = 3'd0;
    id_rs1_data = 8'h00; id_rs2_data = 8'h00; id_imm = 8'h00; id_src2_sel = 2'd0;
    id_mem_read = 1'b0; id_mem_write = 1'b0; id_rf_write_en = 1'b0; id_flag_en = 1'b0;
  endtask

  task automatic wb_set(input logic v, input logic [2:0] rd, input logic [7:0] d);
    wb_valid = v; wb_write_en = v; wb_rd = rd; wb_data = d;
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] r1, input logic [2:0] r2,
                       input logic [2:0] rd, input logic [7:0] d1, input logic [7:0] d2,
                       input logic [7:0] im, input logic [1:0] sel,
                       input logic mr, input logic we, input logic fe);
    id_valid = 1'b1; id_op = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = im; id_src2_sel = sel;
    id_mem_read = mr; id_mem_write = 1'b0; id_rf_write_en = we; id_flag_en = fe;
  endtask

  initial begin
    //          op     a      b      imm    sel   res    c     z
    vecs[0]  = '{4'd0,  8'hF0, 8'h00, 8'h20, 2'd1, 8'h10, 1'b1, 1'b0};
    vecs[1]  = '{4'd1,  8'h01, 8'h01, 8'h00, 2'd0, 8'h03, 1'b0, 1'b0};
    vecs[2]  = '{4'd2,  8'h05, 8'h05, 8'h00, 2'd0, 8'h00, 1'b1, 1'b1};
    vecs[3]  = '{4'd2,  8'h03, 8'h05, 8'h00, 2'd0, 8'hFE, 1'b0, 1'b0};
    vecs[4]  = '{4'd3,  8'h10, 8'h01, 8'h00, 2'd0, 8'h0E, 1'b1, 1'b0};
    vecs[5]  = '{4'd1,  8'hFF, 8'h00, 8'h00, 2'd0, 8'h00, 1'b1, 1'b1};
    vecs[6]  = '{4'd4,  8'hF0, 8'h3C, 8'h00, 2'd0, 8'h30, 1'b0, 1'b0};
    vecs[7]  = '{4'd5,  8'h0F, 8'hF0, 8'h00, 2'd0, 8'hFF, 1'b0, 1'b0};
    vecs[8]  = '{4'd6,  8'hAA, 8'hAA, 8'h00, 2'd0, 8'h00, 1'b0, 1'b1};
    vecs[9]  = '{4'd7,  8'hFF, 8'h0F, 8'h00, 2'd0, 8'hF0, 1'b0, 1'b0};
    vecs[10] = '{4'd12, 8'h33, 8'h00, 8'h5A, 2'd1, 8'h5A, 1'b0, 1'b0};
    vecs[11] = '{4'd9,  8'h81, 8'h00, 8'h01, 2'd2, 8'h40, 1'b1, 1'b0};
    vecs[12] = '{4'd10, 8'h81, 8'h00, 8'h04, 2'd2, 8'h18, 1'b0, 1'b0};
    vecs[13] = '{4'd8,  8'hFF, 8'h00, 8'hF8, 2'd2, 8'hFF, 1'b0, 1'b0};
    vecs[14] = '{4'd8,  8'h81, 8'h00, 8'h01, 2'd2, 8'h02, 1'b1, 1'b0};
    vecs[15] = '{4'd11, 8'h81, 8'h01, 8'h00, 2'd0, 8'hC0, 1'b0, 1'b0};
    vecs[16] = '{4'd9,  8'h04, 8'h00, 8'h03, 2'd1, 8'h00, 1'b1, 1'b1};
    vecs[17] = '{4'd13, 8'hFF, 8'hFF, 8'h00, 2'd0, 8'h00, 1'b0, 1'b1};
    vecs[18] = '{4'd0,  8'h12, 8'h34, 8'h00, 2'd3, 8'h12, 1'b0, 1'b0};
    vecs[19] = '{4'd8,  8'h40, 8'h09, 8'h00, 2'd0, 8'h80, 1'b0, 1'b0};

    idle();
    flush = 1'b0;
    wb_set(1'b0, 3'd0, 8'h00);

    // reset held for two cycles with a valid bundle presented
    rst = 1'b0;
    drive(4'd0, 3'd1, 3'd2, 3'd3, 8'hF0, 8'h00, 8'h20, 2'd1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_em_valid", em_valid, 0);
      chk("rst_em_alu_out", em_alu_out, 0);
      chk("rst_em_store", em_store_data, 0);
      chk("rst_em_rd", em_rd, 0);
      chk("rst_em_ctl", {em_mem_read, em_mem_write, em_rf_write_en}, 0);
      chk("rst_flags", {c_flag, z_flag}, 0);
      chk("rst_id_stall", id_stall, 0);
    end
    idle();
    rst = 1'b1;
    tick();

    // ALU table: no register writes, so no bypass interferes
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].op, 3'd1, 3'd2, 3'd3, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].sel,
            1'b0, 1'b0, 1'b1);
      tick();
      idle();
      tick();
      chk($sformatf("vec%0d_valid", i), em_valid, 1);
      chk($sformatf("vec%0d_res", i), em_alu_out, vecs[i].exp_res);
      chk($sformatf("vec%0d_c", i), c_flag, vecs[i].exp_c);
      chk($sformatf("vec%0d_z", i), z_flag, vecs[i].exp_z);
      chk($sformatf("vec%0d_store", i), em_store_data, vecs[i].b);
    end

    // EX/MEM bypass at distance 1; a conflicting WB entry must lose
    drive(4'd0, 3'd0, 3'd0, 3'd1, 8'h50, 8'h00, 8'h05, 2'd1, 1'b0, 1'b1, 1'b1);
    tick();
    drive(4'd6, 3'd1, 3'd1, 3'd4, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 1'b1);
    wb_set(1'b1, 3'd1, 8'h99);
    tick();
    idle();
    tick();
    wb_set(1'b0, 3'd0, 8'h00);
    chk("byp1_res", em_alu_out, 8'h00);
    chk("byp1_z", z_flag, 1);
    chk("byp1_store", em_store_data, 8'h55);
    chk("byp1_rd", em_rd, 3'd4);

    // WB bypass at distance 2
    drive(4'd0, 3'd0, 3'd0, 3'd1, 8'h50, 8'h00, 8'h05, 2'd1, 1'b0, 1'b1, 1'b1);
    tick();
    idle();
    tick();
    chk("byp2_add_z", z_flag, 0);
    drive(4'd6, 3'd1, 3'd1, 3'd4, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 1'b1);
    wb_set(1'b1, 3'd1, 8'h55);
    tick();
    idle();
    tick();
    wb_set(1'b0, 3'd0, 8'h00);
    chk("byp2_res", em_alu_out, 8'h00);
    chk("byp2_z", z_flag, 1);
    chk("byp2_store", em_store_data, 8'h55);

    // load-use: LD r2 then ADD r3 = r2 + r2
    drive(4'd0, 3'd5, 3'd0, 3'd2, 8'h40, 8'h00, 8'h00, 2'd1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(4'd0, 3'd2, 3'd2, 3'd3, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("lu_stall_hi", id_stall, 1);
    tick();
    chk("lu_stall_lo", id_stall, 0);
    chk("lu_ld_valid", em_valid, 1);
    chk("lu_ld_mem_read", em_mem_read, 1);
    chk("lu_ld_addr", em_alu_out, 8'h40);
    wb_set(1'b1, 3'd2, 8'h07);
    tick();
    chk("lu_bubble_valid", em_valid, 0);
    chk("lu_bubble_ctl", {em_mem_read, em_mem_write, em_rf_write_en}, 0);
    chk("lu_stall_after", id_stall, 0);
    idle();
    tick();
    wb_set(1'b0, 3'd0, 8'h00);
    chk("lu_add_valid", em_valid, 1);
    chk("lu_add_res", em_alu_out, 8'h0E);
    chk("lu_add_rd", em_rd, 3'd3);
    chk("lu_add_store", em_store_data, 8'h07);

    // flush a valid flag-setting ADD: flags must keep C=1,Z=1
    drive(4'd0, 3'd1, 3'd0, 3'd1, 8'hFF, 8'h00, 8'h01, 2'd1, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    chk("fl_pre_flags", {c_flag, z_flag}, 2'b11);
    drive(4'd0, 3'd1, 3'd0, 3'd1, 8'h01, 8'h00, 8'h01, 2'd1, 1'b0, 1'b1, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    tick();
    chk("fl_valid", em_valid, 0);
    chk("fl_rf_we", em_rf_write_en, 0);
    chk("fl_flags", {c_flag, z_flag}, 2'b11);

    // flush together with a load-use hazard still reports the stall
    drive(4'd0, 3'd5, 3'd0, 3'd2, 8'h20, 8'h00, 8'h00, 2'd1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(4'd0, 3'd6, 3'd2, 3'd3, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    chk("flst_stall", id_stall, 1);
    tick();
    flush = 1'b0;
    idle();
    tick();
    chk("flst_bubble", em_valid, 0);

    // reset with two bundles in flight
    drive(4'd0, 3'd1, 3'd0, 3'd1, 8'hF0, 8'h00, 8'h20, 2'd1, 1'b0, 1'b1, 1'b1);
    tick();
    drive(4'd0, 3'd1, 3'd0, 3'd2, 8'h01, 8'h00, 8'h01, 2'd1, 1'b0, 1'b1, 1'b1);
    tick();
    chk("mr_pre_c", c_flag, 1);
    idle();
    rst = 1'b0;
    tick();
    chk("mr_valid", em_valid, 0);
    chk("mr_alu", em_alu_out, 0);
    chk("mr_rd", em_rd, 0);
    chk("mr_ctl", {em_mem_read, em_mem_write, em_rf_write_en}, 0);
    chk("mr_flags", {c_flag, z_flag}, 0);
    rst = 1'b1;
    tick();
    chk("mr_lost", em_valid, 0);
    chk("mr_lost_flags", {c_flag, z_flag}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage_pipe.md
# ex_stage_pipe

Parametrised execute-stage slice for the pipelined processor: ID/EX pipeline register, operand forwarding, load-use stall detection, ALU with carry/zero flag registers, and the EX/MEM pipeline register. It sits between the decode stage (controller and register file) and data memory. It generalises word and register-ID width and adds bypassing, hazard stalls and flush, which the current pipeline lacks.

## Interface
- WORD_LEN, 8, datapath width in bits (≥4)
- RID_LEN, 3, register-ID width
- SHAMT_LEN, $clog2(WORD_LEN), shift-amount bits taken from operand b
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset: one clock; reset is synchronous and active-low
- id_valid  in  1  decode bundle present
- id_op  in  4  ALU operation
- id_rs1, id_rs2, id_rd  in  RID_LEN each  source and destination IDs
- id_rs1_data, id_rs2_data  in  WORD_LEN each  register-file read data
- id_imm  in  WORD_LEN  immediate, already extended
- id_src2_sel  in  2  ALU operand b: 0 = rs2, 1 = imm, 2 = {0, imm[SHAMT_LEN-1:0]}, 3 = treated as 0
- id_mem_read, id_mem_write, id_rf_write_en, id_flag_en  in  1 each  control bits
- flush  in  1  discard the bundle currently presented at ID
- id_stall  out  1  load-use hazard; decode must hold its bundle (combinational)
- wb_valid, wb_write_en  in  1 each  writeback stage state
- wb_rd  in  RID_LEN; wb_data  in  WORD_LEN  writeback destination and value
- em_valid, em_mem_read, em_mem_write, em_rf_write_en  out  1 each  EX/MEM controls
- em_alu_out, em_store_data  out  WORD_LEN each  address/result and store data
- em_rd  out  RID_LEN  destination
- c_flag, z_flag  out  1 each  flag registers

## Operation
- ID/EX register update priority: rst low → clear; else flush or id_stall → bubble (valid 0, every control bit 0); else capture the ID bundle.
- id_stall = ID/EX valid & ID/EX mem_read & id_valid & (ID/EX rd == id_rs1, or ID/EX rd == id_rs2 when id_src2_sel==0 or id_mem_write).
- Forwarding, per source operand: EX/MEM match (em_valid & em_rf_write_en & !em_mem_read & em_rd == rs) wins; else WB match (wb_valid & wb_write_en & wb_rd == rs); else the captured RF data. rs2 forwarding also feeds em_store_data.
- ALU ops, a = fwd rs1, b = selected operand:
  - 0 ADD: a+b.
  - 1 ADDC: a+b+C.
  - 2 SUB: a+~b+1.
  - 3 SUBC: a+~b+C.
  - C = carry-out of the WORD_LEN+1 bit sum (1 = no borrow).
  - 4 AND, 5 OR, 6 XOR, 7 MASK (a&~b), 12 PASSB (b): C = 0.
  - 8 SHL, 9 SHR: shift by s = b[SHAMT_LEN-1:0]. C = last bit shifted out; C = 0 when s = 0.
  - 10 ROL, 11 ROR: rotate by s; C = 0.
  - 13–15: result 0, C = 0.
  - Z = (result == 0) for every op.
- C and Z load only when ID/EX valid & flag_en. A flag consumer immediately after a producer therefore sees the new flags without a hazard.
- EX/MEM register captures ID/EX valid, controls, rd, the ALU result and forwarded rs2 every cycle. A bubble propagates as valid 0 with all controls 0.

## Timing
- Reset values: all valid and control outputs 0; em_alu_out, em_store_data and em_rd 0; c_flag = z_flag = 0; id_stall 0.
- Latency: a bundle presented before edge N appears on the em_* outputs after edge N+1. Flags update at edge N+1.
- Load-use: id_stall is high for exactly one cycle. At edge N+2 the load sits at WB and the consumer reaches EX, taking the value from the WB bypass.
- flush together with id_stall: a bubble is inserted, and id_stall still reports the hazard.
- rst low mid-stream: both pipeline registers and the flags clear at that edge, and in-flight bundles are lost.

## Test plan
- Reset: hold rst=0 for 2 cycles with id_valid=1. All em_* outputs, flags and id_stall stay 0 throughout.
- Arithmetic and carry chain:
  - ADD with rs1=0xF0, imm=0x20, flag_en → em_alu_out=0x10, C=1, Z=0.
  - The next ADDC with 0x01+0x01 → 0x03, C=0.
- EX/MEM bypass: ADD r1 producing 0x55, then immediately XOR r4=r1^r1 with stale RF data 0x00 → 0x00, Z=1. Repeat at distance 2 using wb_data=0x55 → same result.
- Load-use: LD r2, then ADD r3=r2+r2.
  - id_stall is high for one cycle and a bubble appears at em_valid.
  - With wb_data=0x07 → em_alu_out=0x0E.
- Shifts:
  - SHR 0x81 by 1 → 0x40, C=1.
  - ROL 0x81 by 4 → 0x18, C=0.
  - SHL 0xFF by 0 → 0xFF, C=0.
- Flush and mid-operation reset:
  - flush on a valid ADD with flag_en → em_valid=0 and flags unchanged.
  - rst=0 with two bundles in flight → everything 0 on the next cycle.
